memory_access_unit: RTL and testbench

- Downstream of the control logic unit. Consumes read_mem, write_mem, load_byte and store_byte together with the ALU-computed address and the rs2 store data.
- Runs a multi-cycle handshake on the external data bus and stalls the pipeline until the access completes.
- Returns load data, byte-lane selected and extended, to the writeback mux (mem_to_reg path).

---
 rtl/memory_access_unit.sv | 153 +++++++++++++++
 tb/tb_memory_access_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Load/store unit: drives a multi-cycle data-bus handshake and holds the
// pipeline until the access finishes, returning byte- or word-sized load data.
module memory_access_unit #(
    parameter int TIMEOUT   = 255,
    parameter bit LB_SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] mem_data_out,
    output logic        data_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic          byte_q, byte_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;

    logic [31:0] lane_sh;
    logic [7:0]  lane;
    logic [31:0] load_val;

    // Byte lane picked by the low address bits of the latched request
    assign lane_sh  = bus_rdata >> {addr_q[1:0], 3'b000};
    assign lane     = lane_sh[7:0];
    assign load_val = !byte_q    ? bus_rdata :
                      LB_SIGNED  ? {{24{lane[7]}}, lane} :
                                   {24'b0, lane};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        byte_d  = byte_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mis_d   = mis_q;
        err_d   = err_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = read_mem | write_mem;
                if (read_mem || write_mem) begin
                    addr_d  = address;
                    sdata_d = store_data;
                    byte_d  = write_mem ? store_byte : load_byte;
                    wr_d    = write_mem;
                    mis_d   = 1'b0;
                    err_d   = 1'b0;
                    if (read_mem && write_mem) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = DONE;
                    end else if (!byte_d && address[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        data_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (!bus_busy) begin
                    if (!wr_q) data_d = load_val;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = cnt_q + 1'b1;
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
            byte_q  <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign bus_addr     = {addr_q[31:2], 2'b00};
    assign bus_sel      = byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
    assign bus_wdata    = byte_q ? {4{sdata_q[7:0]}} : sdata_q;
    assign bus_read     = (state_q == ISSUE) && !wr_q;
    assign bus_write    = (state_q == ISSUE) && wr_q;
    assign data_valid   = (state_q == DONE);
    assign mem_data_out = data_q;
    assign misaligned   = mis_q;
    assign bus_error    = err_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Table-driven bench with an expected-result queue for memory_access_unit,
// including timeout, rejection and mid-access reset sequences.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_mem, write_mem, load_byte, store_byte;
    logic [31:0] address, store_data, bus_rdata;
    logic        bus_busy;
    logic [31:0] bus_addr, bus_wdata, mem_data_out;
    logic [3:0]  bus_sel;
    logic        bus_read, bus_write, data_valid, stall, misaligned, bus_error;
    logic [31:0] u_bus_addr, u_bus_wdata, u_mem_data_out;
    logic [3:0]  u_bus_sel;
    logic        u_bus_read, u_bus_write, u_data_valid, u_stall;
    logic        u_misaligned, u_bus_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_access_unit #(.TIMEOUT(4), .LB_SIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .read_mem(read_mem), .write_mem(write_mem),
        .load_byte(load_byte), .store_byte(store_byte),
        .address(address), .store_data(store_data),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_read(bus_read), .bus_write(bus_write),
        .mem_data_out(mem_data_out), .data_valid(data_valid),
        .stall(stall), .misaligned(misaligned), .bus_error(bus_error)
    );

    memory_access_unit #(.TIMEOUT(4), .LB_SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst),
        .read_mem(read_mem), .write_mem(write_mem),
        .load_byte(load_byte), .store_byte(store_byte),
        .address(address), .store_data(store_data),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .bus_addr(u_bus_addr), .bus_wdata(u_bus_wdata), .bus_sel(u_bus_sel),
        .bus_read(u_bus_read), .bus_write(u_bus_write),
        .mem_data_out(u_mem_data_out), .data_valid(u_data_valid),
        .stall(u_stall), .misaligned(u_misaligned), .bus_error(u_bus_error)
    );

    typedef struct {
        logic        rd, wr, lb, sb;
        logic [31:0] addr, sd, rdata;
        int          busy;
        int          strobe;
        logic [31:0] eaddr;
        logic [3:0]  esel;
        logic [31:0] ewdata;
        logic        chkd;
        logic [31:0] edata, edata_u;
        logic        emis, eerr;
        int          estall;
    } vec_t;

    typedef struct {
        logic        chkd;
        logic [31:0] edata, edata_u;
        logic        emis, eerr;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic lb, input logic sb_,
        input logic [31:0] addr, input logic [31:0] sd,
        input logic [31:0] rdata, input int busy, input int strobe,
        input logic [31:0] eaddr, input logic [3:0] esel,
        input logic [31:0] ewdata, input logic chkd,
        input logic [31:0] edata, input logic [31:0] edata_u,
        input logic emis, input logic eerr, input int estall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.lb = lb; v.sb = sb_;
        v.addr = addr; v.sd = sd; v.rdata = rdata; v.busy = busy;
        v.strobe = strobe; v.eaddr = eaddr; v.esel = esel;
        v.ewdata = ewdata; v.chkd = chkd; v.edata = edata;
        v.edata_u = edata_u; v.emis = emis; v.eerr = eerr;
        v.estall = estall;
        return v;
    endfunction

    task automatic idle_inputs();
        read_mem = 0; write_mem = 0; load_byte = 0; store_byte = 0;
    endtask

    task automatic run(input int idx, input vec_t v);
        exp_t e;
        int   st, ns, dvk;
        bit   done;
        string tag;
        tag = $sformatf("v%0d", idx);
        e.chkd = v.chkd; e.edata = v.edata; e.edata_u = v.edata_u;
        e.emis = v.emis; e.eerr = v.eerr;
        sb.push_back(e);
        st = 0; ns = 0; dvk = -1; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            read_mem   = (k == 0) ? v.rd : 1'b0;
            write_mem  = (k == 0) ? v.wr : 1'b0;
            load_byte  = v.lb;
            store_byte = v.sb;
            address    = v.addr;
            store_data = v.sd;
            bus_rdata  = v.rdata;
            bus_busy   = (k < 2 + v.busy);
            #1;
            if (stall) st++;
            if (bus_read || bus_write) begin
                ns++;
                chk({tag, " strobe_dir"}, {30'b0, bus_write, bus_read},
                    32'(v.strobe));
                chk({tag, " bus_addr"}, bus_addr, v.eaddr);
                chk({tag, " bus_sel"}, {28'b0, bus_sel}, {28'b0, v.esel});
                if (bus_write) chk({tag, " bus_wdata"}, bus_wdata, v.ewdata);
            end
            if (data_valid) begin
                done = 1;
                dvk  = k;
                if (sb.size() == 0) begin
                    chk({tag, " sb_empty"}, 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " misaligned"}, {31'b0, misaligned},
                        {31'b0, e.emis});
                    chk({tag, " bus_error"}, {31'b0, bus_error},
                        {31'b0, e.eerr});
                    if (e.chkd) begin
                        chk({tag, " data_s"}, mem_data_out, e.edata);
                        chk({tag, " data_u"}, u_mem_data_out, e.edata_u);
                    end
                end
            end
        end
        idle_inputs();
        if (!done) begin
            chk({tag, " dv_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end else begin
            chk({tag, " dv_cycle"}, 32'(dvk), 32'(v.estall));
        end
        chk({tag, " stall_cycles"}, 32'(st), 32'(v.estall));
        chk({tag, " strobe_count"}, 32'(ns), (v.strobe != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int dv_seen;
        vecs[0]  = mk(1,0,0,0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1,
                      32'h100, 4'hF, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF,
                      0, 0, 3);
        vecs[1]  = mk(1,0,1,0, 32'h103, 32'h0, 32'h80FF1234, 0, 1,
                      32'h100, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 32'h00000080,
                      0, 0, 3);
        vecs[2]  = mk(1,0,1,0, 32'h101, 32'h0, 32'h80FF1234, 2, 1,
                      32'h100, 4'b0010, 32'h0, 1, 32'h00000012, 32'h00000012,
                      0, 0, 5);
        vecs[3]  = mk(0,1,0,1, 32'h202, 32'h000000AB, 32'h0, 0, 2,
                      32'h200, 4'b0100, 32'hABABABAB, 0, 32'h0, 32'h0,
                      0, 0, 3);
        vecs[4]  = mk(0,1,0,0, 32'h300, 32'h12345678, 32'h0, 1, 2,
                      32'h300, 4'hF, 32'h12345678, 0, 32'h0, 32'h0,
                      0, 0, 4);
        vecs[5]  = mk(0,1,0,0, 32'h301, 32'h12345678, 32'h0, 0, 0,
                      32'h0, 4'h0, 32'h0, 1, 32'h0, 32'h0,
                      1, 0, 1);
        vecs[6]  = mk(1,0,0,0, 32'h400, 32'h0, 32'hCAFEF00D, 10, 1,
                      32'h400, 4'hF, 32'h0, 1, 32'h0, 32'h0,
                      0, 1, 6);
        vecs[7]  = mk(1,1,0,0, 32'h500, 32'h0, 32'h11111111, 0, 0,
                      32'h0, 4'h0, 32'h0, 1, 32'h0, 32'h0,
                      0, 1, 1);
        vecs[8]  = mk(1,0,0,0, 32'h102, 32'h0, 32'h22222222, 0, 0,
                      32'h0, 4'h0, 32'h0, 1, 32'h0, 32'h0,
                      1, 0, 1);
        vecs[9]  = mk(1,0,1,0, 32'h106, 32'h0, 32'h00AB0000, 0, 1,
                      32'h104, 4'b0100, 32'h0, 1, 32'hFFFFFFAB, 32'h000000AB,
                      0, 0, 3);
        vecs[10] = mk(1,0,0,0, 32'h600, 32'h0, 32'h13572468, 3, 1,
                      32'h600, 4'hF, 32'h0, 1, 32'h13572468, 32'h13572468,
                      0, 0, 6);

        rst = 1; idle_inputs();
        address = 0; store_data = 0; bus_rdata = 0; bus_busy = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst strobes", {30'b0, bus_write, bus_read}, 32'd0);
        chk("rst data_valid", {31'b0, data_valid}, 32'd0);
        chk("rst mem_data_out", mem_data_out, 32'd0);
        chk("rst flags", {30'b0, misaligned, bus_error}, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk); #1;
        chk("idle stall", {31'b0, stall}, 32'd0);
        chk("idle strobes", {30'b0, bus_write, bus_read}, 32'd0);

        for (int i = 0; i < 11; i++) run(i, vecs[i]);

        // Reset while the access sits in WAIT with the bus still busy
        @(negedge clk);
        read_mem = 1; address = 32'h700; bus_busy = 1;
        @(negedge clk); read_mem = 0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid wait stall", {31'b0, stall}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0; bus_busy = 0;
        #1;
        chk("mid rst stall", {31'b0, stall}, 32'd0);
        chk("mid rst strobes", {30'b0, bus_write, bus_read}, 32'd0);
        dv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (data_valid) dv_seen++;
            @(negedge clk); #1;
        end
        chk("mid rst no dv", 32'(dv_seen), 32'd0);

        run(11, vecs[0]);
        run(12, vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
